// File: rtl/sampler_pkg.sv
// rtl/sampler_pkg.sv - shared types and constants for the truth table sampler
package sampler_pkg;

    localparam int DEFAULT_N_IN      = 3;
    localparam int MAX_SETTLE_CYCLES = 15;
    localparam int SETTLE_CNT_W      = 4;

    typedef enum logic [1:0] {
        SMP_IDLE   = 2'd0,
        SMP_SETTLE = 2'd1,
        SMP_SAMPLE = 2'd2,
        SMP_DONE   = 2'd3
    } sampler_state_e;

endpackage

// File: rtl/truth_table_sampler_if.sv
// rtl/truth_table_sampler_if.sv - harness-side bundle of sweep control, stimulus and results
interface truth_table_sampler_if
    import sampler_pkg::*;
    #(parameter int N_IN = DEFAULT_N_IN);

    logic                   start;
    logic [(1<<N_IN)-1:0]   expected;
    logic                   resp_in;
    logic [N_IN-1:0]        stim_out;
    logic                   busy;
    logic                   done;
    logic [(1<<N_IN)-1:0]   table_out;
    logic                   match;
    logic [N_IN-1:0]        mismatch_idx;
    logic                   unstable;

    modport master (
        output start, expected, resp_in,
        input  stim_out, busy, done, table_out, match, mismatch_idx, unstable
    );

    modport slave (
        input  start, expected, resp_in,
        output stim_out, busy, done, table_out, match, mismatch_idx, unstable
    );

endinterface

// File: rtl/lsb_priority_enc.sv
// rtl/lsb_priority_enc.sv - index of the lowest set bit, 0 when no bit is set
module lsb_priority_enc #(
    parameter int N = 3
) (
    input  logic [(1<<N)-1:0] bits,
    output logic [N-1:0]      idx
);

    // Scan from the top down so the lowest set bit wins the last assignment
    always_comb begin
        idx = '0;
        for (int k = (1 << N) - 1; k >= 0; k--) begin
            if (bits[k]) idx = N'(k);
        end
    end

endmodule

// File: rtl/truth_table_sampler.sv
// rtl/truth_table_sampler.sv - sweep inputs, capture truth table, compare (option: SAMPLER_DOUBLE_SAMPLE_EN)
module truth_table_sampler
    import sampler_pkg::*;
#(
    parameter int N_IN          = DEFAULT_N_IN,
    parameter int SETTLE_CYCLES = 2
) (
    input logic                  clk,
    input logic                  reset_n,
    truth_table_sampler_if.slave bus
);

    localparam int W = 1 << N_IN;

    localparam logic [1:0] ST_IDLE   = SMP_IDLE;
    localparam logic [1:0] ST_SETTLE = SMP_SETTLE;
    localparam logic [1:0] ST_SAMPLE = SMP_SAMPLE;
    localparam logic [1:0] ST_DONE   = SMP_DONE;

    localparam logic [SETTLE_CNT_W-1:0] CNT_RELOAD = SETTLE_CNT_W'(SETTLE_CYCLES);
    localparam logic [N_IN:0]           IDX_LAST   = (N_IN + 1)'(W - 1);

    logic [1:0]              state;
    logic [N_IN:0]           idx;
    logic [SETTLE_CNT_W-1:0] cnt;
    logic [W-1:0]            expected_q;
    logic [W-1:0]            table_q;
    logic [W-1:0]            table_nxt;
    logic                    match_q;
    logic [N_IN-1:0]         mm_idx_q;
    logic [N_IN-1:0]         mm_idx_nxt;
    logic                    combo_end;
    logic                    last_combo;

`ifdef SAMPLER_DOUBLE_SAMPLE_EN
    logic phase_q;
    logic first_q;
    logic unstable_q;

    // The second sample closes the combination; only the first is written to the table
    assign combo_end = (state == ST_SAMPLE) && phase_q;

    // Table bit takes the first sample of each combination
    always_comb begin
        table_nxt = table_q;
        if (state == ST_SAMPLE && !phase_q) table_nxt[idx[N_IN-1:0]] = bus.resp_in;
    end

    assign bus.unstable = unstable_q;
`else
    assign combo_end = (state == ST_SAMPLE);

    // Table as it will look after this edge's sample
    always_comb begin
        table_nxt = table_q;
        if (state == ST_SAMPLE) table_nxt[idx[N_IN-1:0]] = bus.resp_in;
    end

    assign bus.unstable = 1'b0;
`endif

    assign last_combo = combo_end && (idx == IDX_LAST);

    // Verdict is computed from the completed table so it is valid in the done cycle
    lsb_priority_enc #(.N(N_IN)) u_enc (
        .bits (table_nxt ^ expected_q),
        .idx  (mm_idx_nxt)
    );

    // Sweep FSM, index/settle counters and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cnt        <= '0;
            expected_q <= '0;
            table_q    <= '0;
            match_q    <= 1'b0;
            mm_idx_q   <= '0;
`ifdef SAMPLER_DOUBLE_SAMPLE_EN
            phase_q    <= 1'b0;
            first_q    <= 1'b0;
            unstable_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        expected_q <= bus.expected;
                        table_q    <= '0;
                        match_q    <= 1'b0;
                        mm_idx_q   <= '0;
                        idx        <= '0;
                        cnt        <= CNT_RELOAD;
`ifdef SAMPLER_DOUBLE_SAMPLE_EN
                        phase_q    <= 1'b0;
                        unstable_q <= 1'b0;
`endif
                        state      <= (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= 1) state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    table_q <= table_nxt;
`ifdef SAMPLER_DOUBLE_SAMPLE_EN
                    if (!phase_q) begin
                        first_q <= bus.resp_in;
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        if (bus.resp_in != first_q) unstable_q <= 1'b1;
                    end
`endif
                    if (combo_end) begin
                        if (last_combo) begin
                            state    <= ST_DONE;
                            idx      <= '0;
                            match_q  <= (table_nxt == expected_q);
                            mm_idx_q <= mm_idx_nxt;
                        end else begin
                            idx <= idx + 1'b1;
                            cnt <= CNT_RELOAD;
                            if (SETTLE_CYCLES != 0) state <= ST_SETTLE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.stim_out     = idx[N_IN-1:0];
    assign bus.busy         = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign bus.done         = (state == ST_DONE);
    assign bus.table_out    = table_q;
    assign bus.match        = match_q;
    assign bus.mismatch_idx = mm_idx_q;

endmodule

// File: tb/tb_truth_table_sampler.sv
// tb/tb_truth_table_sampler.sv - directed self-checking bench for truth_table_sampler
module tb_truth_table_sampler;

`ifdef SAMPLER_DOUBLE_SAMPLE_EN
    localparam int CPC = 4;
`else
    localparam int CPC = 3;
`endif
    localparam int DONE_CYC = 8 * CPC + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic glitch = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   dc;

    always #5 clk = ~clk;

    function automatic logic h_model(input logic [2:0] s);
        return (s[2] & s[1]) | s[0];
    endfunction

    truth_table_sampler_if #(.N_IN(3)) bus ();

    truth_table_sampler #(.N_IN(3), .SETTLE_CYCLES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always_comb bus.resp_in = h_model(bus.stim_out) ^ glitch;

`ifdef SAMPLER_DOUBLE_SAMPLE_EN
    logic glitch2 = 1'b0;
    truth_table_sampler_if #(.N_IN(3)) bus2 ();

    truth_table_sampler #(.N_IN(3), .SETTLE_CYCLES(0)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    always_comb bus2.resp_in = h_model(bus2.stim_out) ^ glitch2;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_sweep(input logic [7:0] exp);
        bus.expected = exp;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.start = 1'b1;
        bus.expected = 8'hEA;
        repeat (3) tick();
        n_cmp++; if (bus.stim_out !== 3'd0) begin n_bad++; $display("FAIL reset_stim: got %0d want 0", bus.stim_out); end
        n_cmp++; if ({bus.busy, bus.done} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done: got %b want 00", {bus.busy, bus.done}); end
        n_cmp++; if (bus.table_out !== 8'h00) begin n_bad++; $display("FAIL reset_table: got %h want 00", bus.table_out); end
        n_cmp++; if ({bus.match, bus.mismatch_idx, bus.unstable} !== 5'b0) begin n_bad++; $display("FAIL reset_results: got %b want 00000", {bus.match, bus.mismatch_idx, bus.unstable}); end
        reset_n = 1'b1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_release_idle: busy got %b want 0", bus.busy); end
        tick();
        bus.start = 1'b0;
        cyc = 1;
        n_cmp++; if ({bus.busy, bus.stim_out} !== 4'b1000) begin n_bad++; $display("FAIL reset_first_sweep: busy/stim got %b want 1000", {bus.busy, bus.stim_out}); end
        wait_done(dc);
        n_cmp++; if (dc !== DONE_CYC) begin n_bad++; $display("FAIL reset_sweep_done_cycle: got %0d want %0d", dc, DONE_CYC); end
        tick();
    endtask

    task automatic test_golden();
        start_sweep(8'hEA);
        n_cmp++; if ({bus.busy, bus.stim_out} !== 4'b1000) begin n_bad++; $display("FAIL golden_cycle1: busy/stim got %b want 1000", {bus.busy, bus.stim_out}); end
        wait_done(dc);
        n_cmp++; if (dc !== DONE_CYC) begin n_bad++; $display("FAIL golden_done_cycle: got %0d want %0d", dc, DONE_CYC); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL golden_busy_at_done: got %b want 0", bus.busy); end
        n_cmp++; if (bus.table_out !== 8'hEA) begin n_bad++; $display("FAIL golden_table: got %h want ea", bus.table_out); end
        n_cmp++; if (bus.match !== 1'b1) begin n_bad++; $display("FAIL golden_match: got %b want 1", bus.match); end
        n_cmp++; if (bus.mismatch_idx !== 3'd0) begin n_bad++; $display("FAIL golden_mm_idx: got %0d want 0", bus.mismatch_idx); end
        n_cmp++; if (bus.unstable !== 1'b0) begin n_bad++; $display("FAIL golden_unstable: got %b want 0", bus.unstable); end
        n_cmp++; if (bus.stim_out !== 3'd0) begin n_bad++; $display("FAIL golden_stim_at_done: got %0d want 0", bus.stim_out); end
        tick();
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL golden_done_pulse: got %b want 0", bus.done); end
        n_cmp++; if ({bus.match, bus.table_out} !== 9'h1EA) begin n_bad++; $display("FAIL golden_hold: got %h want 1ea", {bus.match, bus.table_out}); end
    endtask

    task automatic test_mismatch();
        tick();
        start_sweep(8'hAA);
        wait_done(dc);
        n_cmp++; if (dc !== DONE_CYC) begin n_bad++; $display("FAIL mismatch_done_cycle: got %0d want %0d", dc, DONE_CYC); end
        n_cmp++; if (bus.table_out !== 8'hEA) begin n_bad++; $display("FAIL mismatch_table: got %h want ea", bus.table_out); end
        n_cmp++; if (bus.match !== 1'b0) begin n_bad++; $display("FAIL mismatch_match: got %b want 0", bus.match); end
        n_cmp++; if (bus.mismatch_idx !== 3'd6) begin n_bad++; $display("FAIL mismatch_idx: got %0d want 6", bus.mismatch_idx); end
        tick();
    endtask

    task automatic test_start_during_busy();
        start_sweep(8'hEA);
        while (cyc < 5) tick();
        bus.expected = 8'hAA;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++; if ({bus.busy, bus.stim_out} !== 4'b1001) begin n_bad++; $display("FAIL busy_start_ignored: busy/stim got %b want 1001", {bus.busy, bus.stim_out}); end
        wait_done(dc);
        n_cmp++; if (dc !== DONE_CYC) begin n_bad++; $display("FAIL busy_done_cycle: got %0d want %0d", dc, DONE_CYC); end
        n_cmp++; if ({bus.match, bus.mismatch_idx} !== 4'b1000) begin n_bad++; $display("FAIL busy_orig_expected: match/idx got %b want 1000", {bus.match, bus.mismatch_idx}); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++; if ({bus.busy, bus.match} !== 2'b01) begin n_bad++; $display("FAIL done_start_ignored: busy/match got %b want 01", {bus.busy, bus.match}); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++; if ({bus.busy, bus.stim_out} !== 4'b1000) begin n_bad++; $display("FAIL restart_after_done: busy/stim got %b want 1000", {bus.busy, bus.stim_out}); end
        cyc = 1;
        wait_done(dc);
        n_cmp++; if ({bus.match, bus.mismatch_idx} !== 4'b0110) begin n_bad++; $display("FAIL restart_new_expected: match/idx got %b want 0110", {bus.match, bus.mismatch_idx}); end
        tick();
    endtask

    task automatic test_mid_reset();
        start_sweep(8'hEA);
        for (int i = 0; i < 100 && bus.stim_out !== 3'd4; i++) tick();
        n_cmp++; if (bus.stim_out !== 3'd4) begin n_bad++; $display("FAIL midreset_reach4: got %0d want 4", bus.stim_out); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({bus.busy, bus.stim_out, bus.table_out} !== 12'h000) begin n_bad++; $display("FAIL midreset_immediate: busy/stim/table got %h want 000", {bus.busy, bus.stim_out, bus.table_out}); end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        start_sweep(8'hEA);
        wait_done(dc);
        n_cmp++; if (dc !== DONE_CYC) begin n_bad++; $display("FAIL midreset_fresh_done: got %0d want %0d", dc, DONE_CYC); end
        n_cmp++; if ({bus.match, bus.table_out} !== 9'h1EA) begin n_bad++; $display("FAIL midreset_fresh_table: got %h want 1ea", {bus.match, bus.table_out}); end
        tick();
    endtask

`ifdef SAMPLER_DOUBLE_SAMPLE_EN
    task automatic test_double_sample();
        bus2.expected = 8'hEA;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        cyc = 1;
        dc = -1;
        for (int i = 0; i < 100; i++) begin
            glitch2 = (cyc == 12);
            if (bus2.done) begin
                dc = cyc;
                break;
            end
            tick();
        end
        glitch2 = 1'b0;
        n_cmp++; if (dc !== 17) begin n_bad++; $display("FAIL dsample_done_cycle: got %0d want 17", dc); end
        n_cmp++; if (bus2.unstable !== 1'b1) begin n_bad++; $display("FAIL dsample_unstable: got %b want 1", bus2.unstable); end
        n_cmp++; if (bus2.table_out !== 8'hEA) begin n_bad++; $display("FAIL dsample_table: got %h want ea", bus2.table_out); end
        n_cmp++; if (bus2.match !== 1'b1) begin n_bad++; $display("FAIL dsample_match: got %b want 1", bus2.match); end
        tick();
        n_cmp++; if (bus2.unstable !== 1'b1) begin n_bad++; $display("FAIL dsample_sticky: got %b want 1", bus2.unstable); end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.expected = 8'h00;
`ifdef SAMPLER_DOUBLE_SAMPLE_EN
        bus2.start = 1'b0;
        bus2.expected = 8'h00;
`endif
        test_reset();
        test_golden();
        test_mismatch();
        test_start_during_busy();
        test_mid_reset();
`ifdef SAMPLER_DOUBLE_SAMPLE_EN
        test_double_sample();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/truth_table_sampler.md
# truth_table_sampler

Synthesizable sweep-and-capture engine for 3-input combinational lab blocks. On `start`, it drives every input combination onto the block under test and waits a programmable settle time. It then samples the block's single output and assembles the result into a truth table, which is compared against an expected table. The block sits on the response side of the lab harness: it consumes the DUT output and reports pass/fail plus the first failing input index, replacing manual waveform inspection.

## Interface
- `N_IN`, 3: number of DUT inputs. Sweep length is 2**N_IN.
- `SETTLE_CYCLES`, 2: extra cycles each combination is held before sampling. Legal range is 0–15.

- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begins a sweep; accepted only in IDLE.
- `expected`  in  2**N_IN: expected table, latched on the accepting edge.
- `stim_out`  out  N_IN: drive to DUT. For N_IN=3, bit2=a, bit1=b, bit0=c.
- `resp_in`  in  1: DUT output.
- `busy`  out  1: high while sweeping.
- `done`  out  1: one-cycle pulse when results are valid.
- `table_out`  out  2**N_IN: bit k = sampled `resp_in` while `stim_out`==k.
- `match`  out  1: `table_out`==latched `expected`.
- `mismatch_idx`  out  N_IN: lowest k where the tables differ; 0 if `match`.
- `unstable`  out  1: double-sample disagreement seen (see Configuration).

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE + `start`=1: latch `expected`, clear `table_out`/`match`/`mismatch_idx`/`unstable`, set idx=0, load settle count=SETTLE_CYCLES, go to SETTLE. If SETTLE_CYCLES=0, go directly to SAMPLE.
- SETTLE: decrement the count; at 0, go to SAMPLE.
- SAMPLE: `table_out[idx]` <= `resp_in`.
  - If idx==2**N_IN-1, go to DONE.
  - Otherwise idx++, reload the count, and go to SETTLE (or stay in SAMPLE if SETTLE_CYCLES=0).
- DONE: `done`=1, `match` and `mismatch_idx` registered, `stim_out` returns to 0, then go to IDLE.
- `start` in SETTLE, SAMPLE or DONE is ignored. It is not queued.
- Held `start` retriggers on the first IDLE cycle after DONE.
- idx counter is N_IN+1 bits wide; the terminal test is on idx, never on counter wrap.
- `table_out`, `match`, `mismatch_idx` and `unstable` hold until the next accepted `start` or reset.
- `mismatch_idx` is an LSB-first priority encode of `table_out ^ expected_q`.

## Timing
- Reset values: `stim_out`=0, `busy`=0, `done`=0, `table_out`=0, `match`=0, `mismatch_idx`=0, `unstable`=0, FSM=IDLE.
- `reset_n` low takes effect immediately, including mid-sweep. No partial results survive.
- `start` is sampled at edge E0.
  - From cycle 1, `stim_out`=0 and `busy`=1.
  - Each combination is held SETTLE_CYCLES+1 cycles.
  - `resp_in` is sampled at the last edge of each combination's window.
- `done` is asserted in cycle 2**N_IN*(SETTLE_CYCLES+1)+1; with defaults, that is cycle 25.
- `busy` falls in the same cycle that `done` rises.
- `match` and `mismatch_idx` are valid from the `done` cycle onward.
- DUT path is combinational, so `resp_in` must settle within SETTLE_CYCLES+1 cycles of a `stim_out` change.

## Configuration
- `SAMPLER_DOUBLE_SAMPLE_EN` defined:
  - Each combination gets one additional cycle, so a combination takes SETTLE_CYCLES+2 cycles.
  - `resp_in` is sampled on the last two edges. `table_out[idx]` takes the first sample.
  - Any disagreement sets sticky `unstable`=1.
  - `done` moves to cycle 2**N_IN*(SETTLE_CYCLES+2)+1.
- Not defined: single sample per combination; `unstable` is tied to 0.

## Structure
- `sampler_pkg` contains:
  - the FSM state enum;
  - the default N_IN;
  - the maximum SETTLE_CYCLES constant;
  - the settle-counter width.
- One sub-module: `lsb_priority_enc`, which is combinational and maps 2**N_IN bits to an N_IN-bit index of the lowest set bit (0 when none).
- Counters and FSM live in `truth_table_sampler`.

## Test plan
- Reset:
  - Stimulus: hold `reset_n`=0 for 3 cycles with `start`=1.
  - Required: all outputs 0, FSM in IDLE.
  - After release: sweep begins one cycle after the first edge.
- Golden match:
  - Stimulus: DUT model h=(a&b)|c, `expected`=8'hEA, defaults.
  - Required: `done` pulse in cycle 25, `table_out`=8'hEA, `match`=1, `mismatch_idx`=0.
- Mismatch:
  - Stimulus: same DUT model, `expected`=8'hAA.
  - Required: `table_out`=8'hEA, `match`=0, `mismatch_idx`=6.
- Start during busy:
  - Stimulus: pulse `start` at cycles 5 and 25 with a different `expected`.
  - Required: both pulses ignored; the original latched `expected` is used.
  - Stimulus: pulse `start` at cycle 26.
  - Required: new sweep begins with `stim_out`=0 in cycle 27.
- Mid-sweep reset:
  - Stimulus: assert `reset_n`=0 while `stim_out`=3'd4.
  - Required: outputs immediately take reset values.
  - Then: a fresh `start` runs a full 25-cycle sweep.
- Double sample (macro defined, SETTLE_CYCLES=0):
  - Stimulus: `resp_in` toggles between the two samples of combination 5.
  - Required: `unstable`=1, `table_out[5]` equals the first sample, `done` in cycle 17.
